// File: rtl/nand_pkg.sv
// Shared opcodes, state encoding and address-cycle count for the NAND flash target.
package nand_pkg;

    localparam logic [7:0] CMD_READ0  = 8'h00;
    localparam logic [7:0] CMD_READ1  = 8'h01;
    localparam logic [7:0] CMD_SEQIN  = 8'h80;
    localparam logic [7:0] CMD_PROG   = 8'h10;
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_STATUS = 8'h70;

    localparam int ADDR_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BUSY  = 3'd2,
        ST_RDATA = 3'd3,
        ST_WDATA = 3'd4
    } state_t;

endpackage

// File: rtl/nand_flash_target_if.sv
// NAND flash bus between the controller (master) and the target (slave).
interface nand_flash_target_if;

    logic [7:0] f_io_in;
    logic [7:0] f_io_out;
    logic       f_io_oe;
    logic       f_cle;
    logic       f_ale;
    logic       f_ren;
    logic       f_wen;
    logic       f_rb;

    modport master (
        output f_io_in, f_cle, f_ale, f_ren, f_wen,
        input  f_io_out, f_io_oe, f_rb
    );

    modport slave (
        input  f_io_in, f_cle, f_ale, f_ren, f_wen,
        output f_io_out, f_io_oe, f_rb
    );

endinterface

// File: rtl/nand_strobe_sync.sv
// Two-flop synchroniser for the flash bus inputs with WEN/REN edge pulses.
module nand_strobe_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_io,
    input  logic       i_cle,
    input  logic       i_ale,
    input  logic       i_ren,
    input  logic       i_wen,
    output logic [7:0] o_io,
    output logic       o_cle,
    output logic       o_ale,
    output logic       o_ren,
    output logic       o_wen_rise,
    output logic       o_ren_fall,
    output logic       o_ren_rise
);

    // {io, cle, ale, ren, wen}; idle bus has strobes high, latches low
    localparam logic [11:0] IDLE_LVL = 12'b0000_0000_0011;

    logic [11:0] r_meta;
    logic [11:0] r_sync;
    logic        r_ren_d;
    logic        r_wen_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= IDLE_LVL;
            r_sync  <= IDLE_LVL;
            r_ren_d <= 1'b1;
            r_wen_d <= 1'b1;
        end else begin
            r_meta  <= {i_io, i_cle, i_ale, i_ren, i_wen};
            r_sync  <= r_meta;
            r_ren_d <= r_sync[1];
            r_wen_d <= r_sync[0];
        end
    end

    assign o_io       = r_sync[11:4];
    assign o_cle      = r_sync[3];
    assign o_ale      = r_sync[2];
    assign o_ren      = r_sync[1];
    assign o_wen_rise = r_sync[0] & ~r_wen_d;
    assign o_ren_fall = ~r_sync[1] & r_ren_d;
    assign o_ren_rise = r_sync[1] & ~r_ren_d;

endmodule

// File: rtl/nand_flash_target.sv
// NAND flash device-side responder on a 256K x 8 synchronous array.
// Define STATUS_READ_EN to accept the 70h status-read command.
module nand_flash_target
    import nand_pkg::*;
#(
    parameter int T_READ = 16,
    parameter int T_PROG = 64,
    parameter int T_RST  = 8,
    parameter int AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    nand_flash_target_if.slave  fbus,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_wen,
    output logic [7:0]          mem_d,
    input  logic [7:0]          mem_q
);

    logic [7:0]    w_io;
    logic          w_cle;
    logic          w_ale;
    logic          w_ren;
    logic          w_wen_ev;
    logic          w_ren_fall;
    logic          w_ren_rise;
    logic          w_cmd;
    logic          w_adr;
    logic          w_dat;
    logic          w_busy;
    logic [7:0]    w_stat_byte;
    logic [AW-1:0] w_addr_inc;

    state_t        r_state;
    logic [1:0]    r_acnt;
    logic [7:0]    r_cnt;
    logic          r_rd_busy;
    logic          r_is_read;
    logic          r_stat;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_maddr;
    logic          r_mwen;
    logic [7:0]    r_md;
    logic [7:0]    r_dout;
    logic          r_oe;

    nand_strobe_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_io       (fbus.f_io_in),
        .i_cle      (fbus.f_cle),
        .i_ale      (fbus.f_ale),
        .i_ren      (fbus.f_ren),
        .i_wen      (fbus.f_wen),
        .o_io       (w_io),
        .o_cle      (w_cle),
        .o_ale      (w_ale),
        .o_ren      (w_ren),
        .o_wen_rise (w_wen_ev),
        .o_ren_fall (w_ren_fall),
        .o_ren_rise (w_ren_rise)
    );

    assign w_cmd       = w_wen_ev & w_cle & ~w_ale;
    assign w_adr       = w_wen_ev & ~w_cle & w_ale;
    assign w_dat       = w_wen_ev & ~w_cle & ~w_ale;
    assign w_busy      = (r_state == ST_BUSY);
    assign w_stat_byte = {1'b1, ~w_busy, 6'b0};
    assign w_addr_inc  = r_addr + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acnt    <= 2'd0;
            r_cnt     <= 8'd0;
            r_rd_busy <= 1'b0;
            r_is_read <= 1'b0;
            r_stat    <= 1'b0;
            r_addr    <= '0;
            r_maddr   <= '0;
            r_mwen    <= 1'b1;
            r_md      <= 8'h00;
            r_dout    <= 8'h00;
            r_oe      <= 1'b0;
        end else begin
            r_mwen <= 1'b1;
            r_oe   <= ((r_state == ST_RDATA) || r_stat) && !w_ren;

            // read busy doubles as the prefetch window for the first byte
            if (w_busy) begin
                if (r_rd_busy)
                    r_maddr <= r_addr;
                if (r_cnt == 8'd0)
                    r_state <= r_rd_busy ? ST_RDATA : ST_IDLE;
                else
                    r_cnt <= r_cnt - 8'd1;
            end

            if (r_stat && w_ren_fall) begin
                r_dout <= w_stat_byte;
            end else if (r_state == ST_RDATA) begin
                if (w_ren_fall)
                    r_dout <= mem_q;
                if (w_ren_rise) begin
                    r_addr  <= w_addr_inc;
                    r_maddr <= w_addr_inc;
                end
            end

            if (w_cmd && w_busy) begin
                if (w_io == CMD_RESET) begin
                    r_cnt     <= 8'(T_RST - 1);
                    r_rd_busy <= 1'b0;
                    r_stat    <= 1'b0;
                end
`ifdef STATUS_READ_EN
                else if (w_io == CMD_STATUS)
                    r_stat <= 1'b1;
`endif
            end else if (w_cmd) begin
                r_stat <= 1'b0;
                case (w_io)
                    CMD_READ0, CMD_READ1: begin
                        r_state   <= ST_ADDR;
                        r_acnt    <= 2'd0;
                        r_is_read <= 1'b1;
                        r_addr[8] <= w_io[0];
                    end
                    CMD_SEQIN: begin
                        r_state   <= ST_ADDR;
                        r_acnt    <= 2'd0;
                        r_is_read <= 1'b0;
                        r_addr[8] <= 1'b0;
                    end
                    CMD_PROG: begin
                        if (r_state == ST_WDATA) begin
                            r_state   <= ST_BUSY;
                            r_cnt     <= 8'(T_PROG - 1);
                            r_rd_busy <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    CMD_RESET: begin
                        r_state   <= ST_BUSY;
                        r_cnt     <= 8'(T_RST - 1);
                        r_rd_busy <= 1'b0;
                    end
`ifdef STATUS_READ_EN
                    CMD_STATUS: begin
                        r_state <= ST_IDLE;
                        r_stat  <= 1'b1;
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_adr && r_state == ST_ADDR) begin
                r_acnt <= r_acnt + 2'd1;
                if (r_acnt == 2'd0) begin
                    r_addr[7:0] <= w_io;
                end else if (r_acnt == 2'd1) begin
                    r_addr[16:9] <= w_io;
                end else if (r_acnt == 2'(ADDR_CYCLES - 1)) begin
                    r_addr[AW-1] <= w_io[0];
                    if (r_is_read) begin
                        r_state   <= ST_BUSY;
                        r_cnt     <= 8'(T_READ - 1);
                        r_rd_busy <= 1'b1;
                    end else begin
                        r_state <= ST_WDATA;
                    end
                end
            end else if (w_dat && r_state == ST_WDATA) begin
                r_maddr <= r_addr;
                r_md    <= w_io;
                r_mwen  <= 1'b0;
                r_addr  <= w_addr_inc;
            end
        end
    end

    assign fbus.f_io_out = r_dout;
    assign fbus.f_io_oe  = r_oe;
    assign fbus.f_rb     = ~w_busy;
    assign mem_addr      = r_maddr;
    assign mem_wen       = r_mwen;
    assign mem_d         = r_md;

endmodule

// File: tb/tb_nand_flash_target.sv
// Self-checking bench for nand_flash_target: vector table, directed corner
// sequences and randomized program/read-back against a byte-array model.
module tb_nand_flash_target;

    localparam int T_READ = 16;
    localparam int T_PROG = 64;
    localparam int T_RST  = 8;
    localparam int AW     = 18;
    localparam int MSZ    = 1 << AW;

    typedef struct {
        logic [7:0] op;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         ea;
    } rvec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [7:0]    mem_d;
    logic [7:0]    mem_q;

    always #5 clk = ~clk;

    nand_flash_target_if bus ();

    nand_flash_target #(
        .T_READ (T_READ),
        .T_PROG (T_PROG),
        .T_RST  (T_RST),
        .AW     (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fbus     (bus),
        .mem_addr (mem_addr),
        .mem_wen  (mem_wen),
        .mem_d    (mem_d),
        .mem_q    (mem_q)
    );

    // external array: synchronous read, write on low mem_wen
    logic [7:0]    mem [MSZ];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;
    int            wen_pulses = 0;

    always @(posedge clk) begin
        if (!mem_wen)
            mem[mem_addr] <= mem_d;
        if (pl_en)
            mem[pl_addr] <= pl_data;
        mem_q <= mem[mem_addr];
        if (!rst && !mem_wen)
            wen_pulses <= wen_pulses + 1;
    end

    int cur_busy = 0;
    int last_busy = 0;
    int nbusy = 0;

    always @(negedge clk) begin
        if (!bus.f_rb) begin
            cur_busy <= cur_busy + 1;
        end else if (cur_busy != 0) begin
            last_busy <= cur_busy;
            cur_busy  <= 0;
            nbusy     <= nbusy + 1;
        end
    end

    logic [7:0] exp_mem [int];
    logic [7:0] pdata [$];
    int errors = 0;
    int checks = 0;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int faddr(input int a8, input int b0,
                                 input int b1, input int b2);
        return (b0 + 256 * a8 + 512 * b1 + 131072 * (b2 % 2)) % MSZ;
    endfunction

    task automatic bus_cycle(input logic cle, input logic ale,
                             input logic [7:0] d);
        bus.f_cle   = cle;
        bus.f_ale   = ale;
        bus.f_io_in = d;
        bus.f_wen   = 1'b0;
        tick(3);
        bus.f_wen   = 1'b1;
        tick(4);
        bus.f_cle   = 1'b0;
        bus.f_ale   = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] op);
        bus_cycle(1'b1, 1'b0, op);
    endtask

    task automatic adr(input logic [7:0] b);
        bus_cycle(1'b0, 1'b1, b);
    endtask

    task automatic dat(input logic [7:0] b);
        bus_cycle(1'b0, 1'b0, b);
    endtask

    task automatic ren_pulse(output logic [7:0] d, output logic on,
                             output logic off);
        bus.f_ren = 1'b0;
        tick(5);
        d  = bus.f_io_out;
        on = bus.f_io_oe;
        bus.f_ren = 1'b1;
        tick(5);
        off = bus.f_io_oe;
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        pl_addr = AW'(a);
        pl_data = d;
        pl_en   = 1'b1;
        tick(1);
        pl_en   = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic wait_busy_end(input string nm, input int n0,
                                 input int len);
        int k = 0;
        while (nbusy == n0 && k < 3000) begin
            tick(1);
            k++;
        end
        if (nbusy == n0)
            chk({nm, "_timeout"}, 0, 1);
        else
            chk(nm, last_busy, len);
    endtask

    task automatic prog(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2);
        int a = faddr(0, b0, b1, b2);
        int n0 = nbusy;
        cmd(8'h80);
        adr(b0);
        adr(b1);
        adr(b2);
        foreach (pdata[i]) begin
            dat(pdata[i]);
            exp_mem[(a + i) % MSZ] = pdata[i];
        end
        cmd(8'h10);
        wait_busy_end("prog_busy_len", n0, T_PROG);
        chk("prog_rb_after", bus.f_rb, 1);
        foreach (pdata[i])
            chk("prog_array", mem[(a + i) % MSZ], exp_mem[(a + i) % MSZ]);
    endtask

    task automatic rd(input logic [7:0] op, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2,
                      input int n, input int a);
        int n0;
        logic [7:0] d;
        logic on, off;
        for (int i = 0; i < n; i++)
            if (!exp_mem.exists((a + i) % MSZ))
                preload((a + i) % MSZ, 8'($urandom));
        n0 = nbusy;
        cmd(op);
        adr(b0);
        adr(b1);
        adr(b2);
        wait_busy_end("rd_busy_len", n0, T_READ);
        for (int i = 0; i < n; i++) begin
            ren_pulse(d, on, off);
            chk("rd_oe_low_ren", on, 1);
            chk("rd_data", d, exp_mem[(a + i) % MSZ]);
            chk("rd_oe_high_ren", off, 0);
        end
    endtask

    initial begin
        rvec_t vt [6];
        int rb0 [6];
        int rb1 [6];
        int rb2 [6];
        int rln [6];
        int n0;
        int w0;
        int k;
        logic [7:0] d;
        logic on, off;

        vt[0] = '{8'h00, 8'h12, 8'h34, 8'h01, 'h26812};
        vt[1] = '{8'h01, 8'h12, 8'h34, 8'h01, 'h26912};
        vt[2] = '{8'h01, 8'hFF, 8'hFF, 8'h01, 'h3FFFF};
        vt[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 'h00000};
        vt[4] = '{8'h01, 8'hAB, 8'hCD, 8'hFE, 'h19BAB};
        vt[5] = '{8'h00, 8'h01, 8'h80, 8'h03, 'h30001};

        rst = 1'b1;
        bus.f_io_in = 8'h00;
        bus.f_cle   = 1'b0;
        bus.f_ale   = 1'b0;
        bus.f_ren   = 1'b1;
        bus.f_wen   = 1'b1;
        tick(3);
        chk("rst_rb", bus.f_rb, 1);
        chk("rst_oe", bus.f_io_oe, 0);
        chk("rst_io_out", bus.f_io_out, 8'h00);
        chk("rst_mem_wen", mem_wen, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_d", mem_d, 8'h00);
        rst = 1'b0;
        tick(2);

        pdata = '{8'hAA, 8'h55, 8'h0F};
        prog(8'h12, 8'h34, 8'h01);
        chk("prog_26812", mem['h26812], 8'hAA);
        chk("prog_26813", mem['h26813], 8'h55);
        chk("prog_26814", mem['h26814], 8'h0F);

        preload('h26912, 8'hC3);
        preload('h26913, 8'h3C);
        rd(8'h01, 8'h12, 8'h34, 8'h01, 2, 'h26912);

        // 3FEFFh is the closest 80h can land below the top; run 258 bytes
        pdata.delete();
        for (int i = 0; i < 256; i++)
            pdata.push_back(8'($urandom));
        pdata.push_back(8'h11);
        pdata.push_back(8'h22);
        prog(8'hFF, 8'hFF, 8'h01);
        chk("wrap_3ffff", mem['h3FFFF], 8'h11);
        chk("wrap_00000", mem[0], 8'h22);

        foreach (vt[i])
            rd(vt[i].op, vt[i].b0, vt[i].b1, vt[i].b2, 2, vt[i].ea);

        cmd(8'h80);
        adr(8'h05);
        adr(8'h06);
        n0 = nbusy;
        cmd(8'hFF);
        wait_busy_end("rstcmd_busy_len", n0, T_RST);
        w0 = wen_pulses;
        dat(8'h5A);
        dat(8'hA5);
        tick(4);
        chk("rstcmd_no_wen", wen_pulses, w0);
        chk("rstcmd_rb", bus.f_rb, 1);

        cmd(8'h00);
        adr(8'h10);
        adr(8'h20);
        adr(8'h00);
        k = 0;
        while (bus.f_rb && k < 20) begin
            tick(1);
            k++;
        end
        chk("arst_busy_seen", bus.f_rb, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_rb", bus.f_rb, 1);
        chk("arst_oe", bus.f_io_oe, 0);
        chk("arst_mem_wen", mem_wen, 1);
        chk("arst_mem_addr", mem_addr, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        rd(8'h00, 8'h10, 8'h20, 8'h00, 2, 'h4010);

        for (int r = 0; r < 6; r++) begin
            rb0[r] = int'($urandom_range(0, 255));
            rb1[r] = int'($urandom_range(0, 255));
            rb2[r] = int'($urandom_range(0, 255));
            rln[r] = int'($urandom_range(1, 4));
            pdata.delete();
            for (int i = 0; i < rln[r]; i++)
                pdata.push_back(8'($urandom));
            prog(8'(rb0[r]), 8'(rb1[r]), 8'(rb2[r]));
        end
        for (int r = 0; r < 6; r++)
            rd(8'h00, 8'(rb0[r]), 8'(rb1[r]), 8'(rb2[r]), rln[r],
               faddr(0, rb0[r], rb1[r], rb2[r]));

`ifdef STATUS_READ_EN
        n0 = nbusy;
        cmd(8'h80);
        adr(8'h40);
        adr(8'h00);
        adr(8'h00);
        dat(8'h77);
        exp_mem['h40] = 8'h77;
        cmd(8'h10);
        cmd(8'h70);
        ren_pulse(d, on, off);
        chk("status_busy", d, 8'h80);
        chk("status_busy_oe", on, 1);
        chk("status_busy_oe_off", off, 0);
        wait_busy_end("status_busy_len", n0, T_PROG);
        ren_pulse(d, on, off);
        chk("status_ready", d, 8'hC0);
        chk("status_ready_oe", on, 1);
        chk("status_prog_array", mem['h40], 8'h77);
`else
        w0 = wen_pulses;
        cmd(8'h70);
        ren_pulse(d, on, off);
        chk("nostatus_oe", on, 0);
        chk("nostatus_rb", bus.f_rb, 1);
        chk("nostatus_no_wen", wen_pulses, w0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
